// File: rtl/cla_pkg.sv
// Shared constants and the second-level lookahead function for the pipelined CLA.
package cla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned GROUP_BITS = 4;
  // Widest slice supported is MAX_GROUPS * GROUP_BITS bits.
  localparam int unsigned MAX_GROUPS = 32;

  // Carry into group idx as a flat sum of products over group P/G, so no
  // group waits on the carry of its neighbour.
  function automatic logic group_carry(input logic [MAX_GROUPS-1:0] p,
                                       input logic [MAX_GROUPS-1:0] g,
                                       input logic                  cin,
                                       input int unsigned           idx);
    logic c;
    logic term;
    c = 1'b0;
    for (int unsigned j = 0; j < MAX_GROUPS; j++) begin
      if (j < idx) begin
        term = g[j];
        for (int unsigned m = 0; m < MAX_GROUPS; m++) begin
          if ((m > j) && (m < idx)) term = term & p[m];
        end
        c = c | term;
      end
    end
    term = cin;
    for (int unsigned m = 0; m < MAX_GROUPS; m++) begin
      if (m < idx) term = term & p[m];
    end
    return c | term;
  endfunction

endpackage

// File: rtl/cla_group_4bit.sv
// 4-bit carry-lookahead group: sum plus group propagate/generate for the next level.
module cla_group_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       p,
  output logic       g
);

  logic [3:0] bp;
  logic [3:0] bg;
  logic [3:0] c;

  assign bp = a ^ b;
  assign bg = a & b;

  assign c[0] = cin;
  assign c[1] = bg[0] | (bp[0] & cin);
  assign c[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & cin);
  assign c[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0]) |
                (bp[2] & bp[1] & bp[0] & cin);

  assign sum = bp ^ c;
  assign p   = &bp;
  assign g   = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1]) |
               (bp[3] & bp[2] & bp[1] & bg[0]);

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one slice per stage, carry registered
// between slices, whole-pipe stall on output backpressure.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned S  = WIDTH / STAGES;
  localparam int unsigned NG = S / GROUP_BITS;

  if ((STAGES < 1) || (STAGES > WIDTH / GROUP_BITS) ||
      ((WIDTH % (GROUP_BITS * STAGES)) != 0) || (NG > MAX_GROUPS)) begin : g_bad_params
    $error("cla_adder_pipe: WIDTH must be a multiple of 4*STAGES, STAGES in 1..WIDTH/4");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic [STAGES-1:0] vld_q, src_vld;
  logic [STAGES-1:0] carry_q, carry_d;
  // Operand registers hold the not-yet-summed upper slices right-aligned; the sum
  // register shifts completed slices down from the top, so it is in place at the end.
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign b_eff    = (in_sub == OP_SUB) ? ~in_b : in_b;
  assign c0       = (in_sub == OP_ADD) ? in_cin : 1'b1;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0]      a_in, b_in, sum_in;
    logic                  c_in;
    logic [S-1:0]          sum_sl;
    logic [NG-1:0]         gp, gg;
    logic [NG:0]           gc;
    logic [MAX_GROUPS-1:0] gp_ext, gg_ext;

    if (k == 0) begin : g_first
      assign a_in       = in_a;
      assign b_in       = b_eff;
      assign sum_in     = '0;
      assign c_in       = c0;
      assign src_vld[k] = in_valid;
    end else begin : g_next
      assign a_in       = a_q[k-1];
      assign b_in       = b_q[k-1];
      assign sum_in     = sum_q[k-1];
      assign c_in       = carry_q[k-1];
      assign src_vld[k] = vld_q[k-1];
    end

    for (genvar i = 0; i < NG; i++) begin : g_grp
      cla_group_4bit u_grp (
        .a   (a_in[i*GROUP_BITS +: GROUP_BITS]),
        .b   (b_in[i*GROUP_BITS +: GROUP_BITS]),
        .cin (gc[i]),
        .sum (sum_sl[i*GROUP_BITS +: GROUP_BITS]),
        .p   (gp[i]),
        .g   (gg[i])
      );
    end

    assign gp_ext = MAX_GROUPS'(gp);
    assign gg_ext = MAX_GROUPS'(gg);
    for (genvar i = 0; i <= NG; i++) begin : g_carry
      assign gc[i] = group_carry(gp_ext, gg_ext, c_in, i);
    end

    assign a_d[k]     = a_in >> S;
    assign b_d[k]     = b_in >> S;
    assign sum_d[k]   = (sum_in >> S) | (WIDTH'(sum_sl) << (WIDTH - S));
    assign carry_d[k] = gc[NG];

    // Slice top bits are the operand signs in the last stage.
    if (k == STAGES - 1) begin : g_flags
      assign ovf_d  = a_in[S-1] ^ b_in[S-1] ^ sum_sl[S-1] ^ gc[NG];
      assign zero_d = ~|sum_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q <= src_vld;
      // Bubbles leave data untouched so idle operand values never reach the outputs.
      for (int k = 0; k < STAGES; k++) begin
        if (src_vld[k]) begin
          a_q[k]     <= a_d[k];
          b_q[k]     <= b_d[k];
          sum_q[k]   <= sum_d[k];
          carry_q[k] <= carry_d[k];
        end
      end
      if (src_vld[STAGES-1]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_cout  = carry_q[STAGES-1];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule
